// File: rtl/channel_combinator_pkg.sv
// Shared types and helpers for the channel combinator: FSM state encoding,
// unity-gain constant and a generic signed saturation helper.
package channel_combinator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    // Fraction bits carried by the optional per-channel DC estimator.
    localparam int DC_FRAC = 10;

    function automatic int unity_gain(input int gain_frac);
        return 1 << gain_frac;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/channel_corrector.sv
// Per-channel offset/gain correction with saturation and local gain/offset registers.
// Define OFFSET_TRACK_EN to add a DC estimator that is folded into the offset.
module channel_corrector
    import channel_combinator_pkg::*;
#(
    parameter int DATA_W    = 11,
    parameter int GAIN_W    = 12,
    parameter int GAIN_FRAC = 10
)(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
`ifdef OFFSET_TRACK_EN
    input  logic                     enable_i,
`endif
    input  logic                     cfg_we_i,
    input  logic [GAIN_W-1:0]        cfg_gain_i,
    input  logic signed [DATA_W-1:0] cfg_ofs_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic signed [DATA_W-1:0] corr_o
);

    logic [GAIN_W-1:0]        gain_q;
    logic signed [DATA_W-1:0] ofs_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gain_q <= GAIN_W'(unity_gain(GAIN_FRAC));
            ofs_q  <= '0;
        end else if (cfg_we_i) begin
            gain_q <= cfg_gain_i;
            ofs_q  <= cfg_ofs_i;
        end
    end

`ifdef OFFSET_TRACK_EN
    // Two guard bits keep (x<<10 - dc) from overflowing at full-scale swings.
    localparam int DC_W  = DATA_W + DC_FRAC + 2;
    localparam int OFS_W = DATA_W + 2;

    logic signed [DC_W-1:0]  dc_q;
    logic signed [DC_W-1:0]  dc_d;
    logic signed [DC_W-1:0]  dc_err;
    logic signed [OFS_W-1:0] ofs_eff;

    always_comb begin
        dc_err  = (DC_W'(sample_i) <<< DC_FRAC) - dc_q;
        dc_d    = dc_q + (dc_err >>> DC_FRAC);
        ofs_eff = OFS_W'(ofs_q) + OFS_W'(dc_q >>> DC_FRAC);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dc_q <= '0;
        end else if (enable_i) begin
            dc_q <= dc_d;
        end
    end
`else
    localparam int OFS_W = DATA_W;

    logic signed [OFS_W-1:0] ofs_eff;

    assign ofs_eff = ofs_q;
`endif

    localparam int DIFF_W = OFS_W + 1;
    localparam int PROD_W = DIFF_W + GAIN_W + 1;

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    always_comb begin
        diff    = DIFF_W'(sample_i) - DIFF_W'(ofs_eff);
        prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, gain_q}));
        shifted = prod >>> GAIN_FRAC;
        corr_o  = DATA_W'(sat(64'(shifted), DATA_W));
    end

endmodule

// File: rtl/channel_combinator_v3.sv
// N-channel combinator: per-channel correction, then a linear crossfade on channel change.
// Optional OFFSET_TRACK_EN enables per-channel DC tracking inside the correctors.
//
// state | meaning
// IDLE  | output follows the active channel; a new valid select starts a fade
// FADE  | mixing active->target, k steps 1..L; at k==L target becomes active
module channel_combinator_v3
    import channel_combinator_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 11,
    parameter int GAIN_W     = 12,
    parameter int GAIN_FRAC  = 10,
    parameter int XFADE_LOG2 = 3,
    localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable_3M,
    input  logic [SEL_W-1:0]            select,
    input  logic [N_CH-1:0][DATA_W-1:0] data_in,
    input  logic                        cfg_we,
    input  logic [SEL_W-1:0]            cfg_ch,
    input  logic [GAIN_W-1:0]           cfg_gain,
    input  logic signed [DATA_W-1:0]    cfg_ofs,
    output logic signed [DATA_W-1:0]    data_output,
    output logic                        data_valid,
    output logic                        fading
);

    localparam int               KW     = XFADE_LOG2 + 1;
    localparam int               MIX_W  = DATA_W + XFADE_LOG2 + 2;
    localparam logic [KW-1:0]    L_K    = KW'(1 << XFADE_LOG2);
    localparam logic [SEL_W:0]   N_CH_K = (SEL_W + 1)'(N_CH);

    logic signed [DATA_W-1:0] corr [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        channel_corrector #(
            .DATA_W    (DATA_W),
            .GAIN_W    (GAIN_W),
            .GAIN_FRAC (GAIN_FRAC)
        ) u_corr (
            .clk_i      (clk),
            .rst_n_i    (reset),
`ifdef OFFSET_TRACK_EN
            .enable_i   (enable_3M),
`endif
            .cfg_we_i   (cfg_we && (cfg_ch == SEL_W'(g))),
            .cfg_gain_i (cfg_gain),
            .cfg_ofs_i  (cfg_ofs),
            .sample_i   ($signed(data_in[g])),
            .corr_o     (corr[g])
        );
    end

    state_t           state_q, state_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    k_mix;
    logic [SEL_W-1:0] sel_b;
    logic             sel_ok;

    assign sel_ok = ({1'b0, select} < N_CH_K);

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        k_d      = k_q;
        k_mix    = '0;
        sel_b    = target_q;
        if (enable_3M) begin
            case (state_q)
                IDLE: begin
                    // The triggering sample itself is mixed with k=0 (pure active).
                    if (sel_ok && (select != active_q)) begin
                        target_d = select;
                        sel_b    = select;
                        k_d      = KW'(1);
                        state_d  = FADE;
                    end
                end
                FADE: begin
                    k_mix = k_q;
                    if (k_q == L_K) begin
                        active_d = target_q;
                        k_d      = '0;
                        state_d  = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            active_q <= '0;
            target_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
            k_q      <= k_d;
        end
    end

    assign fading = (state_q == FADE);

    logic signed [DATA_W-1:0] a_q, b_q;
    logic [KW-1:0]            kmix_q;
    logic                     s1_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            kmix_q     <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= enable_3M;
            if (enable_3M) begin
                a_q    <= corr[active_q];
                b_q    <= corr[sel_b];
                kmix_q <= k_mix;
            end
        end
    end

    logic [KW-1:0]            w_a;
    logic signed [MIX_W-1:0]  mix_sum;
    logic signed [DATA_W-1:0] mix_y;

    always_comb begin
        w_a     = L_K - kmix_q;
        mix_sum = MIX_W'(a_q) * MIX_W'($signed({1'b0, w_a}))
                + MIX_W'(b_q) * MIX_W'($signed({1'b0, kmix_q}));
        mix_y   = DATA_W'(mix_sum >>> XFADE_LOG2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_output <= '0;
            data_valid  <= 1'b0;
        end else begin
            data_valid <= s1_valid_q;
            if (s1_valid_q) begin
                data_output <= mix_y;
            end
        end
    end

endmodule

// File: tb/tb_channel_combinator_v3.sv
// Scoreboard bench for channel_combinator_v3: directed plan steps plus randomized traffic
// checked against an integer reference model of the correction and crossfade rules.
module tb_channel_combinator_v3;

    localparam int N_CH   = 4;
    localparam int DATA_W = 11;
    localparam int LL     = 8;

    logic                        clk;
    logic                        reset;
    logic                        enable_3M;
    logic [1:0]                  select;
    logic [N_CH-1:0][DATA_W-1:0] data_in;
    logic                        cfg_we;
    logic [1:0]                  cfg_ch;
    logic [11:0]                 cfg_gain;
    logic signed [DATA_W-1:0]    cfg_ofs;
    logic signed [DATA_W-1:0]    data_output;
    logic                        data_valid;
    logic                        fading;

    channel_combinator_v3 dut (
        .clk         (clk),
        .reset       (reset),
        .enable_3M   (enable_3M),
        .select      (select),
        .data_in     (data_in),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_gain    (cfg_gain),
        .cfg_ofs     (cfg_ofs),
        .data_output (data_output),
        .data_valid  (data_valid),
        .fading      (fading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int data;
        bit fad;
        int cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the documented rules.
    int m_gain[N_CH];
    int m_ofs[N_CH];
    int m_active, m_target, m_step;
    bit m_fading;
    int din[N_CH];

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_gain[i] = 1024;
            m_ofs[i]  = 0;
        end
        m_active = 0;
        m_target = 0;
        m_step   = 0;
        m_fading = 0;
    endtask

    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic int m_corr(input int ch, input int x);
        int v;
        v = fdiv((x - m_ofs[ch]) * m_gain[ch], 1024);
        if (v > 1023) v = 1023;
        if (v < -1024) v = -1024;
        return v;
    endfunction

    task automatic model_step(input int sel, output int y, output bit fad);
        int w, a, b;
        if (m_fading) begin
            w = m_step;
            m_step++;
        end else if (sel < N_CH && sel != m_active) begin
            m_target = sel;
            m_fading = 1;
            w        = 0;
            m_step   = 1;
        end else begin
            w        = 0;
            m_target = m_active;
        end
        a = m_corr(m_active, din[m_active]);
        b = m_corr(m_target, din[m_target]);
        y = fdiv(a * (LL - w) + b * w, LL);
        if (m_fading && w == LL) begin
            m_active = m_target;
            m_fading = 0;
        end
        fad = m_fading;
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("data_output", int'(data_output), e.data);
                chk("fading", int'(fading), int'(e.fad));
                chk("valid_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic cfg(input int ch, input int gain, input int ofs);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_gain = 12'(gain);
        cfg_ofs  = 11'(ofs);
        m_gain[ch] = gain;
        m_ofs[ch]  = ofs;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_sample(input int sel, input bit use_lit, input int lit);
        int   y;
        bit   fad;
        exp_t e;
        @(posedge clk); #1;
        for (int i = 0; i < N_CH; i++) data_in[i] = 11'(din[i]);
        select    = 2'(sel);
        enable_3M = 1'b1;
        model_step(sel, y, fad);
        e.data = use_lit ? lit : y;
        e.fad  = fad;
        e.cyc  = cyc + 2;
        sbq.push_back(e);
        @(posedge clk); #1;
        enable_3M = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int fade1[9] = '{0, 100, 200, 300, 400, 500, 600, 700, 800};
    int fade2[9] = '{800, 650, 500, 350, 200, 50, -100, -250, -400};

    initial begin
        int sel_r;
        reset     = 1'b0;
        enable_3M = 1'b0;
        select    = '0;
        data_in   = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_gain  = '0;
        cfg_ofs   = '0;
        for (int i = 0; i < N_CH; i++) din[i] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_data_output", int'(data_output), 0);
        chk("reset_data_valid", int'(data_valid), 0);
        chk("reset_fading", int'(fading), 0);

        for (int i = 0; i < N_CH; i++) din[i] = 100;
        do_sample(0, 1, 100);

        cfg(0, 1536, 8);
        din[0] = 200;  do_sample(0, 1, 288);
        din[0] = -100; do_sample(0, 1, -162);

        cfg(0, 2048, 0);
        din[0] = 1000;  do_sample(0, 1, 1023);
        din[0] = -1024; do_sample(0, 1, -1024);

        cfg(0, 1024, 0);
        din[0] = 0; din[1] = 800; din[2] = -400;
        do_sample(0, 1, 0);
        for (int i = 0; i < 9; i++) do_sample((i < 3) ? 1 : 2, 1, fade1[i]);
        for (int i = 0; i < 9; i++) do_sample(2, 1, fade2[i]);
        do_sample(2, 1, -400);

        // Fade back toward ch0, then reset while a sample is in flight.
        do_sample(0, 1, -400);
        do_sample(0, 1, -350);
        @(posedge clk); #1;
        for (int i = 0; i < N_CH; i++) data_in[i] = 11'(din[i]);
        select    = 2'd0;
        enable_3M = 1'b1;
        @(posedge clk); #1;
        enable_3M = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        chk("midfade_reset_data_output", int'(data_output), 0);
        chk("midfade_reset_fading", int'(fading), 0);
        chk("midfade_reset_valid", int'(data_valid), 0);
        repeat (6) @(posedge clk);
        din[0] = 11; din[1] = 22; din[2] = 33; din[3] = 44;
        do_sample(0, 1, 11);

        sel_r = 0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0)
                cfg($urandom_range(0, N_CH - 1), $urandom_range(0, 4095),
                    int'($urandom_range(0, 2047)) - 1024);
            for (int i = 0; i < N_CH; i++) din[i] = int'($urandom_range(0, 2047)) - 1024;
            if ($urandom_range(0, 9) < 3) sel_r = $urandom_range(0, N_CH - 1);
            do_sample(sel_r, 0, 0);
        end

        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
